// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter: FSM states,
// port-owner encoding and the busy-cycle counter helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int unsigned CNT_W = 8;

    // Saturating increment so a stuck count never wraps back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared word-addressed memory port between an instruction
// fetch requester and a data load/store requester. One access at a time:
// IDLE grants, BUSY holds the memory request, DONE returns a one-cycle ack.
// Misaligned addresses and accesses that outlive TIMEOUT report err and
// complete with zero read data.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              pick_d;
    logic [ADDR_W-1:0] req_addr;
    logic              timeout_hit;

    // Data wins unless it also won last time and a fetch is waiting.
    assign pick_d      = d_req && !(last_q == OWN_D && if_req);
    assign req_addr    = pick_d ? d_addr : if_addr;
    assign timeout_hit = (32'(cnt_q) + 32'd1) >= TIMEOUT;

    // State and latched-access registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            last_q     <= OWN_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Next-state logic: grant in IDLE, wait for mem_ack or timeout in BUSY.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    owner_d = pick_d ? OWN_D : OWN_IF;
                    last_d  = pick_d ? OWN_D : OWN_IF;
                    addr_d  = {2'b00, req_addr[ADDR_W-1:2]};
                    we_d    = pick_d && d_we;
                    wdata_d = pick_d ? d_wdata : '0;
                    cnt_d   = '0;
                    if (req_addr[1:0] != 2'b00) begin
                        // Misaligned: complete straight away without touching memory.
                        err_d   = 1'b1;
                        state_d = DONE;
                        if (pick_d) d_rdata_d  = '0;
                        else        if_rdata_d = '0;
                    end else begin
                        err_d   = 1'b0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                    if (owner_q == OWN_D) d_rdata_d  = mem_rdata;
                    else                  if_rdata_d = mem_rdata;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                    if (owner_q == OWN_D) d_rdata_d  = '0;
                    else                  if_rdata_d = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req   = (state_q == BUSY);
    assign mem_we    = (state_q == BUSY) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ack    = (state_q == DONE) && (owner_q == OWN_IF);
    assign d_ack     = (state_q == DONE) && (owner_q == OWN_D);
    assign err       = (state_q == DONE) && err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner-case
// sequences, and randomized rounds checked against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .err      (err)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Model state: which port won the most recent grant, and memory contents.
    bit          model_last_d;
    logic [31:0] mem_model [64];

    // mode: 0 = normal access, 1 = misaligned, 2 = never acknowledged
    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_word;
        int unsigned delay;
        int unsigned mode;
        logic [31:0] exp_word;
        logic [31:0] exp_rdata;
        bit          chk_rdata;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        if (is_d) begin
            d_req   = 1'b1;
            d_we    = we;
            d_addr  = addr;
            d_wdata = wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = addr;
        end
    endtask

    // Acts as the memory for one access and checks how it completes.
    task automatic complete(input bit is_d, input bit we, input logic [31:0] wdata,
                            input logic [31:0] word, input int unsigned delay,
                            input int unsigned mode, input logic [31:0] exp_rdata,
                            input bit chk_rdata, input bit drop, input bit chk_lat);
        int unsigned busy_n;
        int unsigned exp_busy;
        bit          done;
        busy_n = 0;
        done   = 1'b0;
        model_last_d = is_d;
        exp_busy = (mode == 0) ? delay + 1 : (mode == 2) ? TIMEOUT : 0;
        for (int unsigned n = 0; n < 400 && !done; n++) begin
            tick();
            mem_ack   = 1'b0;
            mem_rdata = $urandom();
            if (n == 0 && chk_lat)
                chk("grant latency", 32'((mode == 1) ? (if_ack | d_ack) : mem_req), 32'd1);
            if (mode == 1)
                chk("misaligned mem_req", 32'(mem_req), 32'd0);
            if (mem_req) begin
                busy_n++;
                chk("mem_addr", mem_addr, word);
                chk("mem_we", 32'(mem_we), 32'(we));
                if (we) chk("mem_wdata", mem_wdata, wdata);
                if (mode == 0 && busy_n == delay + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = we ? $urandom() : mem_model[mem_addr[5:0]];
                    if (we) mem_model[word[5:0]] = wdata;
                end
            end else if (if_ack || d_ack || err) begin
                done = 1'b1;
                chk("if_ack owner", 32'(if_ack), 32'(!is_d));
                chk("d_ack owner", 32'(d_ack), 32'(is_d));
                chk("err", 32'(err), 32'(mode != 0));
                chk("busy cycles", busy_n, exp_busy);
                if (chk_rdata) chk("rdata", is_d ? d_rdata : if_rdata, exp_rdata);
                if (drop) begin
                    if (is_d) d_req = 1'b0;
                    else      if_req = 1'b0;
                end
                tick();
                chk("ack pulse one cycle", 32'({if_ack, d_ack, err}), 32'd0);
            end
        end
        chk("completion seen", 32'(done), 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom();
        if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
        else                           a[1:0] = 2'b00;
        return a;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        model_last_d = 1'b0;
        for (int i = 0; i < 64; i++) mem_model[i] = $urandom();

        //            is_d we   addr          wdata        mem_word      dly mode word          rdata         chk
        vt[0] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,       32'h0401_0800, 2, 0, 32'h0000_0002, 32'h0401_0800, 1'b1};
        vt[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,       32'hDEAD_BEEF, 0, 0, 32'h0000_0004, 32'hDEAD_BEEF, 1'b1};
        vt[2] = '{1'b1, 1'b1, 32'h0000_0400, 32'h0000_060A, 32'h0,       1, 0, 32'h0000_0100, 32'h0,         1'b0};
        vt[3] = '{1'b1, 1'b0, 32'h0000_0402, 32'h0,       32'h0,         0, 1, 32'h0,         32'h0,         1'b1};
        vt[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,       32'h1234_5678, 3, 0, 32'h3FFF_FFFF, 32'h1234_5678, 1'b1};
        vt[5] = '{1'b0, 1'b0, 32'h0000_0001, 32'h0,       32'h0,         0, 1, 32'h0,         32'h0,         1'b1};
        vt[6] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,       32'hA5A5_A5A5, 4, 0, 32'h0000_0020, 32'hA5A5_A5A5, 1'b1};

        // Reset state
        tick(); tick();
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset acks/err", 32'({if_ack, d_ack, err, mem_we}), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset if_rdata", if_rdata, 32'd0);
        chk("reset d_rdata", d_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Directed single-access table
        for (int i = 0; i < 7; i++) begin
            mem_model[vt[i].exp_word[5:0]] = vt[i].mem_word;
            raise(vt[i].is_d, vt[i].we, vt[i].addr, vt[i].wdata);
            complete(vt[i].is_d, vt[i].we, vt[i].wdata, vt[i].exp_word, vt[i].delay,
                     vt[i].mode, vt[i].exp_rdata, vt[i].chk_rdata, 1'b1, 1'b1);
        end

        // Stray mem_ack while idle is ignored
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("stray ack no grant", 32'({mem_req, if_ack, d_ack, err}), 32'd0);
        tick();
        chk("stray ack still idle", 32'({mem_req, if_ack, d_ack, err}), 32'd0);

        // Timeout: memory never answers
        raise(1'b0, 1'b0, 32'h0000_0030, 32'h0);
        complete(1'b0, 1'b0, 32'h0, 32'h0000_000C, 0, 2, 32'h0, 1'b1, 1'b1, 1'b1);
        mem_model[3] = 32'h0BAD_F00D;
        raise(1'b0, 1'b0, 32'h0000_000C, 32'h0);
        complete(1'b0, 1'b0, 32'h0, 32'h0000_0003, 1, 0, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b1);

        // Reset in the middle of an access
        raise(1'b0, 1'b0, 32'h0000_0020, 32'h0);
        tick();
        chk("pre-reset busy", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async reset outputs", 32'({mem_req, mem_we, if_ack, d_ack, err}), 32'd0);
        chk("async reset mem_addr", mem_addr, 32'd0);
        chk("async reset if_rdata", if_rdata, 32'd0);
        chk("async reset d_rdata", d_rdata, 32'd0);
        tick();
        if_req = 1'b0;
        rst = 1'b0;
        model_last_d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post-reset quiet", 32'({mem_req, if_ack, d_ack, err}), 32'd0);
        end
        mem_model[9] = 32'h5555_0009;
        raise(1'b0, 1'b0, 32'h0000_0024, 32'h0);
        complete(1'b0, 1'b0, 32'h0, 32'h0000_0009, 0, 0, 32'h5555_0009, 1'b1, 1'b1, 1'b1);

        // Simultaneous store and fetch: data first, then fetch
        mem_model[4] = 32'h0000_4444;
        raise(1'b1, 1'b1, 32'h0000_0400, 32'h0000_060A);
        raise(1'b0, 1'b0, 32'h0000_0010, 32'h0);
        complete(1'b1, 1'b1, 32'h0000_060A, 32'h0000_0100, 1, 0, 32'h0, 1'b0, 1'b1, 1'b1);
        complete(1'b0, 1'b0, 32'h0, 32'h0000_0004, 0, 0, 32'h0000_4444, 1'b1, 1'b1, 1'b0);

        // Data held continuously with fetch pending: D, I, D
        mem_model[16] = 32'h1616_1616;
        mem_model[17] = 32'h1717_1717;
        raise(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        raise(1'b0, 1'b0, 32'h0000_0044, 32'h0);
        complete(1'b1, 1'b0, 32'h0, 32'h0000_0010, 0, 0, 32'h1616_1616, 1'b1, 1'b0, 1'b1);
        complete(1'b0, 1'b0, 32'h0, 32'h0000_0011, 1, 0, 32'h1717_1717, 1'b1, 1'b1, 1'b0);
        complete(1'b1, 1'b0, 32'h0, 32'h0000_0010, 2, 0, 32'h1616_1616, 1'b1, 1'b1, 1'b0);

        // Randomized rounds against the transaction-level model
        for (int r = 0; r < 120; r++) begin
            int unsigned pat;
            bit          ui, ud, first_d, serve_d, dwe, mis;
            logic [31:0] ia, da, dwd, a, w, exp_rd;
            pat = $urandom_range(1, 3);
            ui  = pat[0];
            ud  = pat[1];
            ia  = rand_addr();
            da  = rand_addr();
            dwe = 1'($urandom_range(0, 1));
            dwd = $urandom();
            if (ui) raise(1'b0, 1'b0, ia, 32'h0);
            if (ud) raise(1'b1, dwe, da, dwd);
            first_d = ud && !(ui && model_last_d);
            for (int k = 0; k < 2; k++) begin
                if (k == 1 && !(ui && ud)) break;
                serve_d = (k == 0) ? first_d : !first_d;
                a       = serve_d ? da : ia;
                w       = a >> 2;
                mis     = (a % 4) != 0;
                exp_rd  = mis ? 32'h0 : mem_model[w[5:0]];
                complete(serve_d, serve_d && dwe, dwd, w, $urandom_range(0, 4),
                         mis ? 1 : 0, exp_rd, mis || !(serve_d && dwe), 1'b1, k == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL take parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL take parameter DATA_W, default 32, data word width.
REQ-003 SHALL take parameter TIMEOUT, default 255, max cycles a granted access may wait for mem_ack.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port if_req  in  1  instruction-fetch request, held until if_ack.
REQ-007 SHALL have port if_addr  in  ADDR_W  fetch byte address.
REQ-008 SHALL have port if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port if_rdata  out  DATA_W  fetched instruction, valid while if_ack is high.
REQ-010 SHALL have port d_req  in  1  data-access request, held until d_ack.
REQ-011 SHALL have port d_we  in  1  1 = store, 0 = load.
REQ-012 SHALL have port d_addr  in  ADDR_W  data byte address.
REQ-013 SHALL have port d_wdata  in  DATA_W  store data.
REQ-014 SHALL have port d_ack  out  1  one-cycle data completion pulse.
REQ-015 SHALL have port d_rdata  out  DATA_W  load data, valid while d_ack is high.
REQ-016 SHALL have port mem_req  out  1  shared memory request, high for the whole access.
REQ-017 SHALL have port mem_we  out  1  shared memory write enable.
REQ-018 SHALL have port mem_addr  out  ADDR_W  word index = {2'b00, addr[ADDR_W-1:2]}.
REQ-019 SHALL have port mem_wdata  out  DATA_W  write data.
REQ-020 SHALL have port mem_rdata  in  DATA_W  read data, valid while mem_ack is high.
REQ-021 SHALL have port mem_ack  in  1  one-cycle memory completion pulse.
REQ-022 SHALL have port err  out  1  one-cycle pulse on timeout or misaligned address.

Function
REQ-023 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-024 IDLE: if any request is pending, SHALL grant one, latch its addr/we/wdata and owner, and enter BUSY on the next edge.
REQ-025 Priority: data SHALL win unless the previous grant went to data and if_req is pending; then fetch SHALL win (alternation, no starvation).
REQ-026 BUSY: mem_req=1 and mem_addr/mem_we/mem_wdata SHALL come from the latched values, stable until exit.
REQ-027 BUSY with mem_ack=1: SHALL register mem_rdata into the owner's rdata and enter DONE.
REQ-028 DONE: SHALL assert the owner's ack for exactly one cycle, then return to IDLE; requests SHALL be ignored in DONE.
REQ-029 Minimum latency: req sampled at edge t gives mem_req from t+1; mem_ack at edge t+k gives ack high during cycle t+k+1.
REQ-030 Store completion SHALL also pulse d_ack; d_rdata is then don't-care.
REQ-031 BUSY SHALL count cycles (8-bit saturating); reaching TIMEOUT without mem_ack SHALL pulse err, pulse the owner's ack with rdata=0, and go IDLE via DONE.
REQ-032 A granted address with addr[1:0] != 00 SHALL skip BUSY, pulse err and the owner's ack with rdata=0 in DONE, and never raise mem_req.
REQ-033 A mem_ack seen outside BUSY SHALL be ignored.
REQ-034 Simultaneous if_req and d_req in IDLE: the loser SHALL stay pending and be granted on the next IDLE visit.

Reset
REQ-035 On rst high: state=IDLE, last-grant=fetch, counter=0; all outputs 0, including rdata regs, mem_addr and mem_wdata.
REQ-036 Reset mid-access SHALL abandon the access immediately with no ack and no err.

Structure
REQ-037 The FSM state encoding and owner encoding (OWN_IF, OWN_D) SHALL live in the shared processor package.
REQ-038 The design SHALL be a single module with no sub-modules.

Verification
REQ-039 if_req, if_addr=0x8, mem_ack 2 cycles after mem_req, mem_rdata=0x04010800 -> mem_addr=2, if_ack once, if_rdata=0x04010800.
REQ-040 if_req and d_req together, d_we=1, d_addr=0x400, d_wdata=0x60A -> data first (mem_addr=0x100, mem_we=1), then fetch; each ack pulses once.
REQ-041 d_req held continuously with if_req pending -> grants alternate D, I, D.
REQ-042 Granted access with mem_ack never asserted -> err and ack at the 255th BUSY cycle, rdata=0, FSM back in IDLE.
REQ-043 d_addr=0x402 -> err and d_ack, mem_req never asserted.
REQ-044 rst asserted during BUSY -> all outputs 0 asynchronously; after release a fresh if_req is served normally.
